// File: rtl/stream_response_checker.sv
// Compares a DUT AXI-style stream against a reference stream beat by beat,
// checks frame boundaries via tlast, and reports run statistics and status.
module stream_response_checker #(
  parameter int DATA_W      = 1,
  parameter int FRAME_LEN   = 8160,
  parameter int NUM_FRAMES  = 1,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 65535,
  parameter int STOP_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] s_dut_tdata,
  input  logic              s_dut_tvalid,
  input  logic              s_dut_tlast,
  output logic              s_dut_tready,
  input  logic [DATA_W-1:0] s_ref_tdata,
  input  logic              s_ref_tvalid,
  output logic              s_ref_tready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  latency,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp
);

  typedef enum logic [1:0] {IDLE, RUN, HALT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] NFRAMES   = CNT_W'(NUM_FRAMES);
  localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    beat_q, beat_d, err_q, err_d, frame_q, frame_d;
  logic [CNT_W-1:0]    lat_q, lat_d, idx_q, idx_d, bif_q, bif_d, idle_q, idle_d;
  logic [DATA_W-1:0]   got_q, got_d, exp_q, exp_d;
  logic                have_err_q, have_err_d, seen_q, seen_d;
  logic                pass_q, pass_d, tout_q, tout_d;
  logic                xfer, frame_end, mism;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign xfer         = (state_q == RUN) & s_dut_tvalid & s_ref_tvalid;
  assign s_dut_tready = xfer;
  assign s_ref_tready = xfer;
  assign frame_end    = (bif_q == LAST_BEAT);
  assign mism         = xfer & ((s_dut_tdata != s_ref_tdata) | (s_dut_tlast != frame_end));

  // Run control: start handling, beat accounting, mismatch capture, exit conditions
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    err_d      = err_q;
    frame_d    = frame_q;
    lat_d      = lat_q;
    idx_d      = idx_q;
    bif_d      = bif_q;
    idle_d     = idle_q;
    got_d      = got_q;
    exp_d      = exp_q;
    have_err_d = have_err_q;
    seen_d     = seen_q;
    pass_d     = pass_q;
    tout_d     = tout_q;
    case (state_q)
      RUN: begin
        // Latency keeps counting through the first transfer cycle, so a
        // transfer N cycles after the start cycle leaves latency = N.
        if (!seen_q) lat_d = sat_inc(lat_q);
        if (xfer) begin
          seen_d = 1'b1;
          beat_d = sat_inc(beat_q);
          idle_d = '0;
          if (frame_end) begin
            bif_d   = '0;
            frame_d = sat_inc(frame_q);
          end else begin
            bif_d = bif_q + 1'b1;
          end
          if (mism) begin
            err_d      = sat_inc(err_q);
            have_err_d = 1'b1;
            if (!have_err_q) begin
              idx_d = beat_q;
              got_d = s_dut_tdata;
              exp_d = s_ref_tdata;
            end
          end
          if (mism && (STOP_ON_ERR != 0)) begin
            state_d = HALT;
          end else if (frame_end && (frame_d == NFRAMES)) begin
            state_d = DONE;
            pass_d  = !(have_err_q || mism);
          end
        end else begin
          idle_d = sat_inc(idle_q);
          if (idle_d == TO_LIMIT) begin
            state_d = DONE;
            tout_d  = 1'b1;
            pass_d  = 1'b0;
          end
        end
      end
      default: begin
        if (start) begin
          state_d    = RUN;
          beat_d     = '0;
          err_d      = '0;
          frame_d    = '0;
          lat_d      = '0;
          idx_d      = '0;
          bif_d      = '0;
          idle_d     = '0;
          got_d      = '0;
          exp_d      = '0;
          have_err_d = 1'b0;
          seen_d     = 1'b0;
          pass_d     = 1'b0;
          tout_d     = 1'b0;
        end
      end
    endcase
  end

  // State and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      err_q      <= '0;
      frame_q    <= '0;
      lat_q      <= '0;
      idx_q      <= '0;
      bif_q      <= '0;
      idle_q     <= '0;
      got_q      <= '0;
      exp_q      <= '0;
      have_err_q <= 1'b0;
      seen_q     <= 1'b0;
      pass_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
      lat_q      <= lat_d;
      idx_q      <= idx_d;
      bif_q      <= bif_d;
      idle_q     <= idle_d;
      got_q      <= got_d;
      exp_q      <= exp_d;
      have_err_q <= have_err_d;
      seen_q     <= seen_d;
      pass_q     <= pass_d;
      tout_q     <= tout_d;
    end
  end

  assign busy          = (state_q == RUN);
  assign done          = (state_q == HALT) || (state_q == DONE);
  assign pass          = pass_q;
  assign timeout       = tout_q;
  assign beat_cnt      = beat_q;
  assign err_cnt       = err_q;
  assign frame_cnt     = frame_q;
  assign latency       = lat_q;
  assign first_err_idx = idx_q;
  assign first_err_got = got_q;
  assign first_err_exp = exp_q;

endmodule

// File: tb/tb_stream_response_checker.sv
// Bench for stream_response_checker: two instances (continue-on-error and
// stop-on-error) share one stimulus; a behavioural model predicts both.
module tb_stream_response_checker;

  localparam int DW = 8;
  localparam int FL = 4;
  localparam int NF = 2;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, start, dv, dl, rv;
  logic [DW-1:0] dd, rd;

  logic          dready [2];
  logic          rready [2];
  logic          busy   [2];
  logic          done   [2];
  logic          pass_o [2];
  logic          tout   [2];
  logic [CW-1:0] beat   [2];
  logic [CW-1:0] errc   [2];
  logic [CW-1:0] frame  [2];
  logic [CW-1:0] lat    [2];
  logic [CW-1:0] fidx   [2];
  logic [DW-1:0] fgot   [2];
  logic [DW-1:0] fexp   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_response_checker #(
    .DATA_W(DW), .FRAME_LEN(FL), .NUM_FRAMES(NF), .CNT_W(CW), .TIMEOUT(TO), .STOP_ON_ERR(0)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .s_dut_tdata(dd), .s_dut_tvalid(dv), .s_dut_tlast(dl), .s_dut_tready(dready[0]),
    .s_ref_tdata(rd), .s_ref_tvalid(rv), .s_ref_tready(rready[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass_o[0]), .timeout(tout[0]),
    .beat_cnt(beat[0]), .err_cnt(errc[0]), .frame_cnt(frame[0]), .latency(lat[0]),
    .first_err_idx(fidx[0]), .first_err_got(fgot[0]), .first_err_exp(fexp[0])
  );

  stream_response_checker #(
    .DATA_W(DW), .FRAME_LEN(FL), .NUM_FRAMES(NF), .CNT_W(CW), .TIMEOUT(TO), .STOP_ON_ERR(1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .s_dut_tdata(dd), .s_dut_tvalid(dv), .s_dut_tlast(dl), .s_dut_tready(dready[1]),
    .s_ref_tdata(rd), .s_ref_tvalid(rv), .s_ref_tready(rready[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass_o[1]), .timeout(tout[1]),
    .beat_cnt(beat[1]), .err_cnt(errc[1]), .frame_cnt(frame[1]), .latency(lat[1]),
    .first_err_idx(fidx[1]), .first_err_got(fgot[1]), .first_err_exp(fexp[1])
  );

  // Model: phase 0 idle, 1 running, 2 halted, 3 finished
  int            mst   [2];
  int            mbeat [2];
  int            merr  [2];
  int            mframe[2];
  int            mlat  [2];
  int            midx  [2];
  int            midle [2];
  logic [DW-1:0] mgot  [2];
  logic [DW-1:0] mexp  [2];
  bit            mseen [2];
  bit            mpass [2];
  bit            mtout [2];
  int            stop_of[2] = '{0, 1};

  task automatic model_clear(input int i);
    mbeat[i] = 0; merr[i] = 0; mframe[i] = 0; mlat[i] = 0; midx[i] = 0;
    midle[i] = 0; mgot[i] = '0; mexp[i] = '0; mseen[i] = 0; mpass[i] = 0; mtout[i] = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    bit x, bad, lastb;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        model_clear(i);
        mst[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        x = (mst[i] == 1) && dv && rv;
        if (mst[i] != 1) begin
          if (start) begin
            model_clear(i);
            mst[i] = 1;
          end
        end else begin
          if (!mseen[i]) mlat[i]++;
          if (x) begin
            lastb = (mbeat[i] % FL) == FL - 1;
            bad   = (dd != rd) || (dl != lastb);
            if (bad && merr[i] == 0) begin
              midx[i] = mbeat[i];
              mgot[i] = dd;
              mexp[i] = rd;
            end
            mbeat[i]++;
            if (bad) merr[i]++;
            mframe[i] = mbeat[i] / FL;
            mseen[i]  = 1;
            midle[i]  = 0;
            if (bad && stop_of[i] != 0) mst[i] = 2;
            else if (mframe[i] == NF) begin
              mst[i]   = 3;
              mpass[i] = (merr[i] == 0);
            end
          end else begin
            midle[i]++;
            if (midle[i] == TO) begin
              mst[i]   = 3;
              mtout[i] = 1;
              mpass[i] = 0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("busy",      i, 32'(busy[i]),   32'(mst[i] == 1));
      chk("done",      i, 32'(done[i]),   32'(mst[i] >= 2));
      chk("dut_ready", i, 32'(dready[i]), 32'((mst[i] == 1) && dv && rv));
      chk("ref_ready", i, 32'(rready[i]), 32'((mst[i] == 1) && dv && rv));
      chk("beat_cnt",  i, 32'(beat[i]),   32'(mbeat[i]));
      chk("err_cnt",   i, 32'(errc[i]),   32'(merr[i]));
      chk("frame_cnt", i, 32'(frame[i]),  32'(mframe[i]));
      chk("latency",   i, 32'(lat[i]),    32'(mlat[i]));
      chk("first_idx", i, 32'(fidx[i]),   32'(midx[i]));
      chk("first_got", i, 32'(fgot[i]),   32'(mgot[i]));
      chk("first_exp", i, 32'(fexp[i]),   32'(mexp[i]));
      chk("timeout",   i, 32'(tout[i]),   32'(mtout[i]));
      if (mst[i] >= 2) chk("pass", i, 32'(pass_o[i]), 32'(mpass[i]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] r, input logic l);
    dv = 1'b1; rv = 1'b1; dd = d; rd = r; dl = l;
    tick();
  endtask

  task automatic quiet;
    dv = 1'b0; rv = 1'b0; dl = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dv = 1'b0; rv = 1'b0; dl = 1'b0; dd = '0; rd = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("lit_reset_busy", 0, 32'(busy[0]), 0);
    chk("lit_reset_beat", 1, 32'(beat[1]), 0);
    tick();

    // Clean run: 8 matching beats, tlast on beats 3 and 7
    do_start();
    for (int i = 0; i < 8; i++) send(DW'(i), DW'(i), (i % 4) == 3);
    quiet();
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("lit_clean_done",  i, 32'(done[i]),  1);
      chk("lit_clean_pass",  i, 32'(pass_o[i]), 1);
      chk("lit_clean_beat",  i, 32'(beat[i]),  8);
      chk("lit_clean_frame", i, 32'(frame[i]), 2);
      chk("lit_clean_err",   i, 32'(errc[i]),  0);
      chk("lit_clean_lat",   i, 32'(lat[i]),   1);
    end

    // Latency: reference valid from the start, DUT valid 5 cycles later
    do_start();
    rv = 1'b1; rd = 8'h11;
    tick(); tick();
    chk("lit_lat_refready", 0, 32'(rready[0]), 0);
    tick(); tick();
    for (int i = 0; i < 8; i++) send(DW'(i + 16), DW'(i + 16), (i % 4) == 3);
    quiet();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("lit_lat_value", i, 32'(lat[i]),   5);
      chk("lit_lat_pass",  i, 32'(pass_o[i]), 1);
    end

    // Data mismatch on beat 2: A5 vs 5A
    do_start();
    for (int i = 0; i < 8; i++)
      send((i == 2) ? 8'hA5 : DW'(i), (i == 2) ? 8'h5A : DW'(i), (i % 4) == 3);
    quiet();
    tick();
    chk("lit_mm_err",  0, 32'(errc[0]), 1);
    chk("lit_mm_idx",  0, 32'(fidx[0]), 2);
    chk("lit_mm_got",  0, 32'(fgot[0]), 32'h A5);
    chk("lit_mm_exp",  0, 32'(fexp[0]), 32'h5A);
    chk("lit_mm_done", 0, 32'(done[0]), 1);
    chk("lit_mm_pass", 0, 32'(pass_o[0]), 0);
    chk("lit_mm_beat", 0, 32'(beat[0]), 8);
    chk("lit_mm_beat", 1, 32'(beat[1]), 3);
    chk("lit_mm_err",  1, 32'(errc[1]), 1);
    chk("lit_mm_busy", 1, 32'(busy[1]), 0);
    chk("lit_mm_pass", 1, 32'(pass_o[1]), 0);

    // Framing: tlast early on beat 2 with matching data
    do_start();
    for (int i = 0; i < 8; i++) send(DW'(i), DW'(i), i == 2);
    dv = 1'b1; rv = 1'b1; dl = 1'b0;
    tick();
    chk("lit_fr_dready", 1, 32'(dready[1]), 0);
    chk("lit_fr_rready", 1, 32'(rready[1]), 0);
    chk("lit_fr_err",    1, 32'(errc[1]), 1);
    chk("lit_fr_beat",   1, 32'(beat[1]), 3);
    chk("lit_fr_done",   1, 32'(done[1]), 1);
    chk("lit_fr_err",    0, 32'(errc[0]), 3);
    quiet();
    tick();

    // Timeout: DUT never valid
    do_start();
    rv = 1'b1;
    repeat (15) tick();
    chk("lit_to_early_done", 0, 32'(done[0]), 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("lit_to_done",    i, 32'(done[i]), 1);
      chk("lit_to_timeout", i, 32'(tout[i]), 1);
      chk("lit_to_pass",    i, 32'(pass_o[i]), 0);
    end
    quiet();
    tick();

    // Reset mid-run after 3 beats, then a fresh run with a start ignored mid-run
    do_start();
    for (int i = 0; i < 3; i++) send(DW'(i), DW'(i), 1'b0);
    dv = 1'b1; rv = 1'b1; dd = 8'd3; rd = 8'd3; dl = 1'b1;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("lit_rst_beat",   i, 32'(beat[i]), 0);
      chk("lit_rst_busy",   i, 32'(busy[i]), 0);
      chk("lit_rst_dready", i, 32'(dready[i]), 0);
      chk("lit_rst_rready", i, 32'(rready[i]), 0);
      chk("lit_rst_lat",    i, 32'(lat[i]), 0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    quiet();
    tick();
    do_start();
    chk("lit_fresh_beat0", 0, 32'(beat[0]), 0);
    for (int i = 0; i < 8; i++) begin
      start = (i == 4);
      send(DW'(i + 100), DW'(i + 100), (i % 4) == 3);
    end
    start = 1'b0;
    quiet();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("lit_fresh_beat", i, 32'(beat[i]), 8);
      chk("lit_fresh_pass", i, 32'(pass_o[i]), 1);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
